// File: rtl/eth_tx_sched_if.sv
// Request/grant handshake between the frame sources, the scheduler and eth_tx.
// The scheduler connects through the master modport; the surrounding logic through slave.
interface eth_tx_sched_if;
    logic [1:0] req;
    logic [1:0] ack;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_sel;
    logic       nlp_start;
    logic       idle;
    logic       err;

    modport master (
        input  req,
        input  tx_busy,
        output ack,
        output tx_start,
        output tx_sel,
        output nlp_start,
        output idle,
        output err
    );

    modport slave (
        output req,
        output tx_busy,
        input  ack,
        input  tx_start,
        input  tx_sel,
        input  nlp_start,
        input  idle,
        input  err
    );
endinterface

// File: rtl/eth_tx_sched.sv
// Round-robin transmit scheduler for the 10BASE-T path: arbitrates two frame sources onto one
// eth_tx, enforces the inter-frame gap and issues normal link pulses while the link is idle.
module eth_tx_sched #(
    parameter int IFG_CYCLES    = 96,
    parameter int NLP_PERIOD    = 160000,
    parameter int START_TIMEOUT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    eth_tx_sched_if.master bus
);
    localparam int NLP_W = (NLP_PERIOD > 2)    ? $clog2(NLP_PERIOD)    : 1;
    localparam int GAP_W = (IFG_CYCLES > 2)    ? $clog2(IFG_CYCLES)    : 1;
    localparam int TO_W  = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [NLP_W-1:0] NLP_LAST = NLP_W'(NLP_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        BUSY,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       req_p0;
    logic             last_q, last_d;
    logic [NLP_W-1:0] nlp_cnt_q, nlp_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]       ack_q, ack_d;
    logic             tx_start_q, tx_start_d;
    logic             tx_sel_q, tx_sel_d;
    logic             nlp_start_q, nlp_start_d;
    logic             idle_q, idle_d;
    logic             err_q, err_d;
    logic             grant_src;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        nlp_cnt_d   = nlp_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        tx_sel_d    = tx_sel_q;
        ack_d       = 2'b00;
        tx_start_d  = 1'b0;
        nlp_start_d = 1'b0;
        err_d       = 1'b0;
        // With both sources asking, the one not served last wins.
        grant_src   = (req_p0 == 2'b11) ? ~last_q : req_p0[1];

        case (state_q)
            IDLE: begin
                if (|req_p0) begin
                    state_d    = WAIT_BUSY;
                    tx_start_d = 1'b1;
                    ack_d      = grant_src ? 2'b10 : 2'b01;
                    tx_sel_d   = grant_src;
                    last_d     = grant_src;
                    nlp_cnt_d  = '0;
                    wait_cnt_d = '0;
                end else if (nlp_cnt_q >= NLP_LAST) begin
                    state_d     = GAP;
                    nlp_start_d = 1'b1;
                    nlp_cnt_d   = '0;
                    gap_cnt_d   = '0;
                end else begin
                    nlp_cnt_d = nlp_cnt_q + NLP_W'(1);
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = BUSY;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d   = GAP;
                    err_d     = 1'b1;
                    gap_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            BUSY: begin
                if (!bus.tx_busy) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                // The gap counts toward the next link-pulse period.
                if (nlp_cnt_q < NLP_LAST) begin
                    nlp_cnt_d = nlp_cnt_q + NLP_W'(1);
                end
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_p0      <= 2'b00;
            last_q      <= 1'b1;
            nlp_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            ack_q       <= 2'b00;
            tx_start_q  <= 1'b0;
            tx_sel_q    <= 1'b0;
            nlp_start_q <= 1'b0;
            idle_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_p0      <= bus.req;
            last_q      <= last_d;
            nlp_cnt_q   <= nlp_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            ack_q       <= ack_d;
            tx_start_q  <= tx_start_d;
            tx_sel_q    <= tx_sel_d;
            nlp_start_q <= nlp_start_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_sel    = tx_sel_q;
    assign bus.nlp_start = nlp_start_q;
    assign bus.idle      = idle_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: reset/timeout vector table, hand-written corner sequences and a
// randomized run against a timestamp-based reference model.
module tb_eth_tx_sched;
    localparam int IFG = 8;
    localparam int NP  = 200;
    localparam int TO  = 4;

    logic clk = 1'b0;
    logic rst_n;
    eth_tx_sched_if bus();

    eth_tx_sched #(
        .IFG_CYCLES   (IFG),
        .NLP_PERIOD   (NP),
        .START_TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic       busy;
        logic [6:0] exp;   // {ack[1:0], tx_start, tx_sel, nlp_start, idle, err}
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(logic r, logic [1:0] q, logic b, logic [1:0] a, logic s,
                                logic sel, logic n, logic i, logic e);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.busy  = b;
        v.exp   = {a, s, sel, n, i, e};
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.ack, bus.tx_start, bus.tx_sel, bus.nlp_start, bus.idle, bus.err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] r);
        rst_n       = 1'b0;
        bus.req     = r;
        bus.tx_busy = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tx_start !== 1'b1 && n < 400);
        chk("start_seen", 32'(bus.tx_start), 32'd1);
    endtask

    task automatic wait_nlp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.nlp_start !== 1'b1 && n < 1000);
        chk("nlp_seen", 32'(bus.nlp_start), 32'd1);
    endtask

    // Reference model: tracks absolute edge times instead of counters.
    int         m_t, m_free, m_start, m_nlp;
    bit         m_in_tx, m_seen, m_last, m_sel;
    logic [1:0] m_req_q;
    logic [6:0] m_exp;

    task automatic model_step(input logic r, input logic [1:0] rq, input logic b);
        logic [1:0] e_ack;
        logic       e_start, e_nlp, e_err, e_idle;
        bit         src;
        e_ack = 2'b00; e_start = 1'b0; e_nlp = 1'b0; e_err = 1'b0;
        if (!r) begin
            m_t = 0; m_free = 0; m_start = 0; m_nlp = 0;
            m_in_tx = 0; m_seen = 0; m_last = 1; m_sel = 0;
            m_req_q = 2'b00;
            e_idle  = 1'b1;
        end else begin
            m_t++;
            if (m_in_tx) begin
                if (!m_seen) begin
                    if (b) m_seen = 1;
                    else if (m_t - m_start >= TO) begin
                        e_err = 1'b1; m_in_tx = 0; m_free = m_t + IFG + 1;
                    end
                end else if (!b) begin
                    m_in_tx = 0; m_free = m_t + IFG + 1;
                end
            end else if (m_t >= m_free) begin
                if (m_req_q != 2'b00) begin
                    src     = (m_req_q == 2'b11) ? !m_last : m_req_q[1];
                    e_ack   = src ? 2'b10 : 2'b01;
                    e_start = 1'b1;
                    m_sel = src; m_last = src; m_nlp = 0;
                    m_in_tx = 1; m_seen = 0; m_start = m_t;
                end else if (m_nlp >= NP - 1) begin
                    e_nlp = 1'b1; m_nlp = 0; m_free = m_t + IFG + 1;
                end else begin
                    m_nlp++;
                end
            end else if (m_nlp < NP - 1) begin
                m_nlp++;
            end
            e_idle  = !m_in_tx && (m_t + 1 >= m_free);
            m_req_q = rq;
        end
        m_exp = {e_ack, e_start, m_sel, e_nlp, e_idle, e_err};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic       cur_rst, cur_busy;
        logic [1:0] cur_req;
        int         rise_at, fall_at;

        // Reset with both requesting, first grant to 0, then a start timeout on source 1.
        for (int i = 0; i < 3; i++) tbl[i] = mk(0, 2'b11, 0, 2'b00, 0, 0, 0, 1, 0);
        tbl[3] = mk(1, 2'b11, 0, 2'b00, 0, 0, 0, 1, 0);
        tbl[4] = mk(1, 2'b11, 0, 2'b01, 1, 0, 0, 0, 0);
        for (int i = 5; i < 8; i++) tbl[i] = mk(1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0);
        tbl[8] = mk(1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 1);
        for (int i = 9; i < 16; i++) tbl[i] = mk(1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 2'b10, 0, 2'b00, 0, 0, 0, 1, 0);
        tbl[17] = mk(1, 2'b10, 0, 2'b10, 1, 1, 0, 0, 0);
        tbl[18] = mk(1, 2'b00, 0, 2'b00, 0, 1, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            rst_n       = tbl[i].rst_n;
            bus.req     = tbl[i].req;
            bus.tx_busy = tbl[i].busy;
            step();
            chk($sformatf("vec[%0d]", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Single frame: one-cycle pulses, idle back IFG+1 edges after busy drops.
        do_reset(2'b00);
        bus.req = 2'b01;
        wait_start(n);
        chk("sf_latency", n, 2);
        chk("sf_ack", 32'(bus.ack), 32'd1);
        chk("sf_sel", 32'(bus.tx_sel), 32'd0);
        bus.req = 2'b00;
        step();
        chk("sf_start_width", 32'(bus.tx_start), 32'd0);
        chk("sf_ack_width", 32'(bus.ack), 32'd0);
        step();
        bus.tx_busy = 1'b1;
        repeat (50) step();
        chk("sf_busy_idle", 32'(bus.idle), 32'd0);
        bus.tx_busy = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.idle !== 1'b1 && n < 300);
        chk("sf_idle_return", n, IFG + 1);

        // Contention: alternate grants, next start exactly after the full gap.
        do_reset(2'b11);
        wait_start(n);
        chk("ct_latency", n, 2);
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("ct_ack[%0d]", f), 32'(bus.ack), (f % 2) ? 32'd2 : 32'd1);
            chk($sformatf("ct_sel[%0d]", f), 32'(bus.tx_sel), 32'(f % 2));
            step();
            bus.tx_busy = 1'b1;
            repeat (5) step();
            bus.tx_busy = 1'b0;
            if (f == 3) bus.req = 2'b00;
            if (f < 3) begin
                wait_start(n);
                chk($sformatf("ct_gap[%0d]", f), n, IFG + 2);
            end
        end

        // Link pulses every NP cycles of idle.
        do_reset(2'b00);
        for (int k = 0; k < 3; k++) begin
            wait_nlp(n);
            chk($sformatf("nlp_period[%0d]", k), n, NP);
        end
        // A request landing on the due cycle wins and clears the counter.
        repeat (NP - 2) step();
        bus.req = 2'b01;
        step();
        chk("col_no_early_nlp", 32'(bus.nlp_start), 32'd0);
        step();
        chk("col_start", 32'(bus.tx_start), 32'd1);
        chk("col_no_nlp", 32'(bus.nlp_start), 32'd0);
        chk("col_ack", 32'(bus.ack), 32'd1);
        bus.req = 2'b00;
        wait_nlp(n);
        chk("col_nlp_after_clear", n, NP + TO);

        // Reset while transmitting.
        do_reset(2'b00);
        bus.req = 2'b10;
        wait_start(n);
        bus.req = 2'b00;
        step();
        bus.tx_busy = 1'b1;
        step();
        step();
        chk("mr_busy_idle", 32'(bus.idle), 32'd0);
        rst_n       = 1'b0;
        bus.tx_busy = 1'b0;
        step();
        chk("mr_reset_vals", 32'(outs()), 32'b00_0_0_0_1_0);
        rst_n   = 1'b1;
        bus.req = 2'b11;
        wait_start(n);
        chk("mr_regrant_latency", n, 2);
        chk("mr_regrant_src", 32'(bus.ack), 32'd1);

        // Randomized traffic against the reference model.
        cur_rst = 1'b0; cur_req = 2'b00; cur_busy = 1'b0;
        rise_at = -1; fall_at = -1;
        for (int c = 0; c < 4000; c++) begin
            rst_n       = cur_rst;
            bus.req     = cur_req;
            bus.tx_busy = cur_busy;
            step();
            model_step(cur_rst, cur_req, cur_busy);
            chk($sformatf("rand[%0d]", c), 32'(outs()), 32'(m_exp));

            cur_rst = !(c < 1 || $urandom_range(0, 599) == 0);
            if (bus.tx_start === 1'b1) begin
                rise_at = c + $urandom_range(1, 6);
                fall_at = rise_at + $urandom_range(1, 12);
            end
            if (!cur_rst) begin
                rise_at = -1;
                fall_at = -1;
            end
            cur_busy = (c + 1 >= rise_at) && (c + 1 < fall_at);
            for (int i = 0; i < 2; i++) begin
                if (bus.ack[i] === 1'b1) cur_req[i] = 1'b0;
                else if (!cur_req[i]) begin
                    if ((c % 1500 < 700) ? ($urandom_range(0, 7) == 0)
                                         : ($urandom_range(0, 399) == 0))
                        cur_req[i] = 1'b1;
                end else if ($urandom_range(0, 99) == 0) cur_req[i] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit scheduler for the 10BASE-T path. It shares one `eth_tx` transmitter between two frame sources using round-robin arbitration. It issues the transmitter's one-cycle start pulse, tracks the transmission through the transmitter's busy flag and enforces the inter-frame gap. During idle periods it also schedules normal link pulses (NLPs). It runs in the `clk_eth` bit-clock domain, between the frame builders and `eth_tx`.

## Interface
- `IFG_CYCLES`, 96: inter-frame gap in clk cycles (bit times), counted from `tx_busy` falling or NLP issue.
- `NLP_PERIOD`, 160000: idle cycles between link pulses (16 ms at 10 MHz).
- `START_TIMEOUT`, 4: cycles allowed for `tx_busy` to rise after `tx_start`.
- `clk` in 1: bit clock; single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in 2: per-source frame request, level; held until the matching `ack` bit.
- `ack` out 2: one-cycle pulse, coincident with `tx_start`, to the granted source.
- `tx_start` out 1: one-cycle start pulse to `eth_tx`.
- `tx_busy` in 1: high while `eth_tx` is sending.
- `tx_sel` out 1: index of the granted source; drives the data mux ahead of `eth_tx`.
- `nlp_start` out 1: one-cycle pulse to the link-pulse generator.
- `idle` out 1: high in IDLE.
- `err` out 1: one-cycle pulse on start timeout.

## Operation
- All outputs are registered.
- Reset values: `ack`=0, `tx_start`=0, `nlp_start`=0, `err`=0, `tx_sel`=0, `idle`=1, state IDLE, NLP counter 0.
- The round-robin pointer `last` resets to 1, so source 0 wins the first contention.
- States: IDLE, WAIT_BUSY, BUSY, GAP.
- IDLE:
  - If any `req` bit is set, grant. With a single requester, grant it. With both requesting, grant the source not equal to `last`.
  - On grant, pulse `tx_start` and `ack[i]`, set `tx_sel`=i and `last`=i, clear the NLP counter, and go to WAIT_BUSY.
  - Otherwise, if the NLP counter is ≥ `NLP_PERIOD`-1, pulse `nlp_start`, clear the counter and go to GAP.
  - A frame request beats an NLP due in the same cycle.
- WAIT_BUSY:
  - If `tx_busy`=1, go to BUSY.
  - If `tx_busy` has not risen after `START_TIMEOUT` cycles, pulse `err` and go to GAP.
- BUSY: go to GAP on the first cycle `tx_busy`=0.
- GAP: count `IFG_CYCLES` cycles, then go to IDLE. `req` is ignored during GAP.
- NLP counter:
  - Increments every cycle outside WAIT_BUSY/BUSY and saturates at `NLP_PERIOD`-1.
  - Is cleared on grant and on `nlp_start`.
  - Width is $clog2(`NLP_PERIOD`).
- `tx_sel` holds its value after the transmission ends and changes only on the next grant.
- A `req` bit dropped before its grant is simply not served; no state is kept.
- Reset asserted mid-operation returns all state and outputs to their reset values on the next edge. The bench is responsible for also resetting `eth_tx`.

## Timing
- Arbitration latency: a `req` sampled at edge N in IDLE gives `tx_start`/`ack` high for exactly the cycle after edge N+1.
- With `tx_busy` rising at edge K (WAIT_BUSY → BUSY) and falling at edge M, BUSY → GAP occurs at edge M+1.
- The earliest next `tx_start` is `IFG_CYCLES`+1 edges after entry into GAP.
- Back-to-back requests from both sources alternate grants: 0, 1, 0, …
- The NLP spacing during continuous idle is exactly `NLP_PERIOD` cycles between `nlp_start` pulses, plus the GAP after each pulse, which is counted into the next period.
- Transition from IDLE to a grant is blocked until GAP completes, even with `req` held.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles while `req`=2'b11 → all pulses 0, `idle`=1, `tx_sel`=0; the first grant after release goes to source 0.
- **Single frame:** `req`=2'b01, and `tx_busy` is driven high 2 cycles after `tx_start` for 50 cycles → `ack`=2'b01 pulse and `tx_start` 1 cycle wide. `idle` returns exactly 96 cycles after `tx_busy` falls, plus 1.
- **Contention:** `req`=2'b11 held for 4 frames → grant order 0, 1, 0, 1; `tx_sel` matches `ack`, and no `tx_start` occurs inside any gap.
- **Start timeout:** `req`=2'b10 with `tx_busy` tied 0 → `err` pulses 4 cycles after `tx_start`, then GAP, then IDLE. A held `req` is re-granted after the gap.
- **NLP** (`NLP_PERIOD`=200, `IFG_CYCLES`=8):
  - With no requests → `nlp_start` pulses every 200 cycles.
  - A `req` arriving in the same cycle an NLP falls due → `tx_start` fires, no `nlp_start`, and the counter clears.
- **Mid-transmission reset:** `rst_n` low while in BUSY → the next cycle shows reset values and the state returns to IDLE.
